chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the 4-bit combinational ripple adder.
- Adds or subtracts WIDTH-bit operands over WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle, LSB slice first.
- The carry is registered between slices, so only a CHUNK-bit adder sits in the critical path.
- Used wherever wide arithmetic must trade latency for area/timing; start/busy/done handshake to the controlling FSM.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- STEPS (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- sub  input  1  0 = add, 1 = subtract; captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- carry_in  input  1  add: carry-in; sub: borrow-in; captured with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is updated
- sum  output  WIDTH  registered result
- carry_out  output  1  add: carry-out; sub: borrow-out
- overflow  output  1  signed (two's complement) overflow of the completed operation

Behaviour:
- Reset: the clock and reset are one clock and a synchronous, active-high rst, as fixed above. rst=1 at an edge forces state=IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, slice counter=0 and clears internal operand/carry registers. rst overrides start.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN: counter reaches STEPS-1 --> DONE.
  - DONE --start--> RUN; DONE with no start --> IDLE.
- Capture edge E0 (start=1 in IDLE or DONE):
  - latch a, sub, effective operand b_eff = sub ? ~b : b, and initial carry c = sub ? ~carry_in : carry_in.
  - counter <= 0, state <= RUN.
- Compute edges E1..E_STEPS: slice k = bits [k*CHUNK +: CHUNK].
  - {c, s_k} = a_k + b_eff_k + c; s_k stored into internal result register; counter increments.
- Completion, edge E_STEPS:
  - sum <= full internal result; carry_out <= sub ? ~c : c.
  - overflow <= (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - state <= DONE; done = 1 for exactly the cycle after E_STEPS.
- Latency: done high in the cycle following edge E_STEPS. WIDTH=16, CHUNK=4 gives 4 compute edges after the capture edge.
- Output stability:
  - sum, carry_out and overflow hold the previous result throughout RUN and change only at completion edges.
  - Values are held indefinitely in IDLE.
- busy is 1 exactly in RUN. done and busy are never high together.
- start while busy (RUN) is ignored; operand inputs changing during RUN have no effect.
- Back-to-back: start=1 during the DONE cycle is accepted. The next capture happens at that edge, so done pulses once per operation with no IDLE gap.
- Subtract semantics: result = a - b - carry_in mod 2^WIDTH; carry_out = 1 iff a < b + carry_in (unsigned).
- CHUNK == WIDTH: STEPS=1; done high 1 cycle after the capture edge.
- Reset mid-RUN: the operation is aborted, done never pulses for it, and all outputs return to 0.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, sum=0x0000, carry_out=0, overflow=0; no capture occurs.
- Add, WIDTH=16/CHUNK=4: a=0x1234, b=0x0FCD, carry_in=1, sub=0, start at E0 -> busy=1 over E1..E4; done=1 only in the cycle after E4; sum=0x2202, carry_out=0, overflow=0; sum unchanged (0) during RUN.
- Carry/overflow:
  - 0xFFFF+0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0.
  - 0x7FFF+0x0001 -> sum=0x8000, carry_out=0, overflow=1.
- Subtract: sub=1, a=0x0005, b=0x0007, carry_in=0 -> sum=0xFFFE, carry_out=1, overflow=0. Then a=0x8000, b=0x0001, carry_in=1 -> sum=0x7FFE, carry_out=0, overflow=1.
- Handshake:
  - start with 0x0001+0x0001; at E2 pulse start with 0x00FF+0x0001 -> ignored, result 0x0002.
  - Assert start in the DONE cycle with 0x00FF+0x0001 -> accepted; second done exactly 5 cycles after the first; sum=0x0100.
- Abort: start 0xAAAA+0x5555, assert rst at E2 -> busy=0 next cycle, done never pulses, sum=0. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : chunked_serial_adder                                        |
// | Function : WIDTH-bit add/subtract, CHUNK bits per cycle, LSB first.    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS   = WIDTH / CHUNK;
    localparam int c_CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STEPS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b_eff;
    logic [WIDTH-1:0]   r_res;
    logic               r_c;
    logic               r_sub;

    int                 w_base;
    logic [CHUNK:0]     w_slice;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_ovf;

    // One CHUNK-wide adder; the partial result merges the current slice so
    // the final edge can publish the complete word directly.
    always_comb begin
        w_base     = int'(r_cnt) * CHUNK;
        w_slice    = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b_eff[w_base +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_c};
        w_res_next = r_res;
        w_res_next[w_base +: CHUNK] = w_slice[CHUNK-1:0];
        w_ovf      = (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b_eff   <= '0;
            r_res     <= '0;
            r_c       <= 1'b0;
            r_sub     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b_eff <= sub ? ~b : b;
                        r_c     <= sub ^ carry_in;
                        r_sub   <= sub;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_res <= w_res_next;
                    r_c   <= w_slice[CHUNK];
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        // Subtraction runs as a + ~b + ~bin, so carry inverts into borrow.
                        sum       <= w_res_next;
                        carry_out <= r_sub ^ w_slice[CHUNK];
                        overflow  <= w_ovf;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= c_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// Bench for chunked_serial_adder: fixed vectors, handshake corner cases and
// randomised operations against an integer-arithmetic reference model.
module tb_chunked_serial_adder;

    localparam int W      = 16;
    localparam int BUDGET = 20;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    chunked_serial_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         ci;
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic on the operands.
    task automatic model(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic ci, output logic [W-1:0] es, output logic eco,
                         output logic eov);
        int ua, ub, sa, sb, u, v;
        ua = int'(va);
        ub = int'(vb);
        sa = int'($signed(va));
        sb = int'($signed(vb));
        if (s) begin
            u   = ua - ub - int'(ci);
            v   = sa - sb - int'(ci);
            eco = (ua < ub + int'(ci));
        end else begin
            u   = ua + ub + int'(ci);
            v   = sa + sb + int'(ci);
            eco = (u > 65535);
        end
        es  = u[W-1:0];
        eov = (v > 32767) || (v < -32768);
    endtask

    // Drive a request at the current time; returns 1 time unit after the capture edge
    // with operand inputs scrambled so late changes would be visible.
    task automatic issue(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic ci);
        start = 1'b1; sub = s; a = va; b = vb; carry_in = ci;
        @(posedge clk);
        #1;
        start = 1'b0; sub = $urandom_range(1); a = W'($urandom); b = W'($urandom);
        carry_in = $urandom_range(1);
    endtask

    // Count negedges until done; busy must stay high and sum must hold meanwhile.
    task automatic wait_done(output int lat);
        logic [W-1:0] prev;
        prev = sum;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done) begin
                chk("busy_in_run", busy, 1);
                chk("sum_hold_in_run", sum, prev);
            end
        end while (!done && lat < BUDGET);
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles", lat);
        end else begin
            chk("busy_low_with_done", busy, 0);
        end
    endtask

    task automatic chk_result(input string nm, input logic [W-1:0] es, input logic eco,
                              input logic eov);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_carry"}, carry_out, eco);
        chk({nm, "_ovf"}, overflow, eov);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] es;
        logic         eco, eov;
        bit           seen;

        tbl[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b1, 16'h2202, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1'b1};

        // Reset held with start asserted.
        rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'hFFFF; b = 16'h0001; carry_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_result("rst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_rst_busy", busy, 0);

        // Fixed vectors; also check the output holds 0 during the first run.
        foreach (tbl[i]) begin
            @(negedge clk);
            issue(tbl[i].s, tbl[i].va, tbl[i].vb, tbl[i].ci);
            wait_done(lat);
            chk("latency", lat, 5);
            chk_result("vec", tbl[i].es, tbl[i].eco, tbl[i].eov);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("hold_sum_idle", sum, tbl[i].es);
        end

        // start pulsed mid-run must be ignored.
        @(negedge clk);
        issue(1'b0, 16'h0001, 16'h0001, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; a = 16'h00FF; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("ignored_start_latency", lat, 3);
        chk_result("ignored_start", 16'h0002, 1'b0, 1'b0);

        // Back-to-back: start accepted in the DONE cycle.
        issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
        wait_done(lat);
        chk("b2b_gap", lat, 5);
        chk_result("b2b", 16'h0100, 1'b0, 1'b0);

        // Abort mid-run.
        @(negedge clk);
        issue(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk_result("abort", 16'h0000, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        @(negedge clk);
        issue(1'b0, 16'hAAAA, 16'h5555, 1'b1);
        wait_done(lat);
        chk("post_abort_latency", lat, 5);
        chk_result("post_abort", 16'h0000, 1'b1, 1'b0);

        // Randomised operations, some issued back-to-back from the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            logic         rs, rci;
            logic [W-1:0] ra, rb;
            rs  = $urandom_range(1);
            rci = $urandom_range(1);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if ($urandom_range(1) == 0) @(negedge clk);
            issue(rs, ra, rb, rci);
            wait_done(lat);
            model(rs, ra, rb, rci, es, eco, eov);
            chk("rand_latency", lat, 5);
            chk_result("rand", es, eco, eov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
